// File: rtl/fpu_seq_muldiv_pkg.sv
// Shared FPU types: operation codes, mul/div sequencer states and flag bit positions.
package pa_fpu;

  typedef enum logic [3:0] {
    op_nop  = 4'd0,
    op_add  = 4'd1,
    op_sub  = 4'd2,
    op_mul  = 4'd3,
    op_div  = 4'd4,
    op_sqrt = 4'd5,
    op_cmp  = 4'd6,
    op_cvt  = 4'd7
  } e_fpu_operations;

  typedef enum logic [2:0] {
    md_idle,
    md_unpack,
    md_mul_iter,
    md_div_iter,
    md_norm,
    md_result
  } e_muldiv_states;

  localparam int unsigned FLAG_INVALID = 3;
  localparam int unsigned FLAG_DZ      = 2;
  localparam int unsigned FLAG_OVF     = 1;
  localparam int unsigned FLAG_UNF     = 0;

endpackage

// File: rtl/fpu_seq_muldiv_if.sv
// Request/result handshake between the FPU main sequencer (master) and the mul/div unit (slave).
interface fpu_seq_muldiv_if #(
  parameter int unsigned W = 32
);
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         ready;
  logic [W-1:0] result;
  logic         out_valid;
  logic         out_ack;
  logic [3:0]   flags;

  modport master (
    output start, op, opa, opb, out_ack,
    input  ready, result, out_valid, flags
  );

  modport slave (
    input  start, op, opa, opb, out_ack,
    output ready, result, out_valid, flags
  );
endinterface

// File: rtl/fpu_seq_muldiv_round_pack.sv
// Combinational round/range-check/pack stage, shared by mul/div and the add/sub unit.
// FPU_MULDIV_ROUND_NEAREST_EN selects round-to-nearest-even; otherwise truncation.
module fpu_round_pack #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                     sign,
  input  logic signed [EXP_W+1:0]  exp_in,
  input  logic [MAN_W:0]           sig_in,
  input  logic                     guard,
  input  logic                     round,
  input  logic                     sticky,
  output logic [EXP_W+MAN_W:0]     result,
  output logic                     ovf,
  output logic                     unf
);
  localparam int unsigned EW = EXP_W + 2;
  localparam logic signed [EW-1:0] MAX_E  = EW'(2**EXP_W - 1);
  localparam logic signed [EW-1:0] ZERO_E = '0;
  localparam logic signed [EW-1:0] ONE_E  = EW'(1);

  logic [MAN_W:0]          sig;
  logic signed [EW-1:0]    exp_r;
  logic [3:0]              unused_bits;
`ifdef FPU_MULDIV_ROUND_NEAREST_EN
  logic                    inc;
  logic [MAN_W+1:0]        sum;
`endif

  assign unused_bits = {guard, round, sticky, sig[MAN_W]};

  always_comb begin
    sig   = sig_in;
    exp_r = exp_in;
`ifdef FPU_MULDIV_ROUND_NEAREST_EN
    inc = guard & (round | sticky | sig_in[0]);
    sum = {1'b0, sig_in} + {{(MAN_W+1){1'b0}}, inc};
    // carry out of the significand means 10.00..0: renormalise
    if (sum[MAN_W+1]) begin
      sig   = sum[MAN_W+1:1];
      exp_r = exp_in + ONE_E;
    end else begin
      sig = sum[MAN_W:0];
    end
`endif
    ovf    = 1'b0;
    unf    = 1'b0;
    result = {sign, exp_r[EXP_W-1:0], sig[MAN_W-1:0]};
    if (exp_r >= MAX_E) begin
      ovf    = 1'b1;
      result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (exp_r <= ZERO_E) begin
      unf    = 1'b1;
      result = {sign, {(EXP_W+MAN_W){1'b0}}};
    end
  end
endmodule

// File: rtl/fpu_seq_muldiv.sv
// Sequential FP multiply (shift-add) / divide (restoring) with special values, flags and ack handshake.
// Rounding mode controlled by FPU_MULDIV_ROUND_NEAREST_EN (see fpu_round_pack).
module fpu_seq_muldiv
  import pa_fpu::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned BIAS  = 2**(EXP_W-1) - 1
) (
  input logic            clk,
  input logic            rst,
  fpu_seq_muldiv_if.slave bus
);
  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned M  = MAN_W + 1;
  localparam int unsigned EW = EXP_W + 2;
  localparam int unsigned CW = $clog2(M + 3);
  localparam logic signed [EW-1:0] BIAS_X = EW'(BIAS);
  localparam logic signed [EW-1:0] ONE_X  = EW'(1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  e_muldiv_states       state_q, state_d;
  e_fpu_operations      op_q, op_d;
  logic [W-1:0]         opa_q, opa_d, opb_q, opb_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 sign_q, sign_d;
  logic signed [EW-1:0] exp_q, exp_d;
  logic [M-1:0]         dvs_q, dvs_d;
  logic [2*M-1:0]       prod_q, prod_d;
  logic [M:0]           rem_q, rem_d;
  logic [M+1:0]         quo_q, quo_d;
  logic [W-1:0]         result_q, result_d;
  logic [3:0]           flags_q, flags_d;

  logic [EXP_W-1:0]     ea, eb;
  logic [MAN_W-1:0]     fa, fb;
  logic                 a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, sgn;
  logic signed [EW-1:0] ea_x, eb_x;
  logic                 spec_hit;
  logic [W-1:0]         spec_res;
  logic [3:0]           spec_flags;
  logic [M:0]           mul_sum, div_diff;
  logic                 div_ge;
  logic [M-1:0]         rp_sig;
  logic                 rp_g, rp_r, rp_s, rp_ovf, rp_unf;
  logic signed [EW-1:0] rp_exp;
  logic [W-1:0]         rp_result;

  assign ea     = opa_q[W-2:MAN_W];
  assign eb     = opb_q[W-2:MAN_W];
  assign fa     = opa_q[MAN_W-1:0];
  assign fb     = opb_q[MAN_W-1:0];
  assign sgn    = opa_q[W-1] ^ opb_q[W-1];
  // zero exponent covers denormals too: they are flushed to zero
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == '1) && (fa == '0);
  assign b_inf  = (eb == '1) && (fb == '0);
  assign a_nan  = (ea == '1) && (fa != '0);
  assign b_nan  = (eb == '1) && (fb != '0);
  assign ea_x   = $signed(EW'(ea));
  assign eb_x   = $signed(EW'(eb));

  always_comb begin
    spec_hit   = 1'b1;
    spec_res   = {sgn, {(W-1){1'b0}}};
    spec_flags = '0;
    if (!(op_q == op_mul || op_q == op_div)) begin
      spec_res                 = QNAN;
      spec_flags[FLAG_INVALID] = 1'b1;
    end else if (a_nan || b_nan) begin
      spec_res = QNAN;
    end else if (op_q == op_mul) begin
      if ((a_inf && b_zero) || (a_zero && b_inf)) begin
        spec_res                 = QNAN;
        spec_flags[FLAG_INVALID] = 1'b1;
      end else if (a_zero || b_zero) begin
        spec_res = {sgn, {(W-1){1'b0}}};
      end else if (a_inf || b_inf) begin
        spec_res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else begin
        spec_hit = 1'b0;
      end
    end else begin
      if ((a_zero && b_zero) || (a_inf && b_inf)) begin
        spec_res                 = QNAN;
        spec_flags[FLAG_INVALID] = 1'b1;
      end else if (a_inf) begin
        spec_res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (b_zero) begin
        spec_res            = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        spec_flags[FLAG_DZ] = 1'b1;
      end else if (a_zero || b_inf) begin
        spec_res = {sgn, {(W-1){1'b0}}};
      end else begin
        spec_hit = 1'b0;
      end
    end
  end

  // one multiplier bit per step: add multiplicand into the high half, shift the pair right
  assign mul_sum  = {1'b0, prod_q[2*M-1:M]} + (prod_q[0] ? {1'b0, dvs_q} : '0);
  assign div_ge   = (rem_q >= {1'b0, dvs_q});
  assign div_diff = div_ge ? (rem_q - {1'b0, dvs_q}) : rem_q;

  always_comb begin
    rp_sig = quo_q[M:1];
    rp_g   = quo_q[0];
    rp_r   = 1'b0;
    rp_s   = (rem_q != '0);
    rp_exp = exp_q - ONE_X;
    if (op_q == op_mul) begin
      if (prod_q[2*M-1]) begin
        rp_sig = prod_q[2*M-1:M];
        rp_g   = prod_q[M-1];
        rp_r   = prod_q[M-2];
        rp_s   = |prod_q[M-3:0];
        rp_exp = exp_q + ONE_X;
      end else begin
        rp_sig = prod_q[2*M-2:M-1];
        rp_g   = prod_q[M-2];
        rp_r   = prod_q[M-3];
        rp_s   = |prod_q[M-4:0];
        rp_exp = exp_q;
      end
    end else if (quo_q[M+1]) begin
      rp_sig = quo_q[M+1:2];
      rp_g   = quo_q[1];
      rp_r   = quo_q[0];
      rp_exp = exp_q;
    end
  end

  fpu_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round_pack (
    .sign   (sign_q),
    .exp_in (rp_exp),
    .sig_in (rp_sig),
    .guard  (rp_g),
    .round  (rp_r),
    .sticky (rp_s),
    .result (rp_result),
    .ovf    (rp_ovf),
    .unf    (rp_unf)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= md_idle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      md_idle:     if (bus.start) state_d = md_unpack;
      md_unpack:   if (spec_hit) state_d = md_result;
                   else if (op_q == op_mul) state_d = md_mul_iter;
                   else state_d = md_div_iter;
      md_mul_iter: if (cnt_q == CW'(1)) state_d = md_norm;
      md_div_iter: if (cnt_q == CW'(1)) state_d = md_norm;
      md_norm:     state_d = md_result;
      md_result:   if (bus.out_ack) state_d = md_idle;
      default:     state_d = md_idle;
    endcase
  end

  always_comb begin
    bus.ready     = (state_q == md_idle);
    bus.out_valid = (state_q == md_result);
    bus.result    = result_q;
    bus.flags     = flags_q;
  end

  always_comb begin
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    dvs_d    = dvs_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      md_idle: if (bus.start) begin
        op_d  = e_fpu_operations'(bus.op);
        opa_d = bus.opa;
        opb_d = bus.opb;
      end
      md_unpack: begin
        sign_d = sgn;
        if (spec_hit) begin
          result_d = spec_res;
          flags_d  = spec_flags;
        end else if (op_q == op_mul) begin
          exp_d  = ea_x + eb_x - BIAS_X;
          dvs_d  = {1'b1, fa};
          prod_d = {{M{1'b0}}, 1'b1, fb};
          cnt_d  = CW'(M);
        end else begin
          exp_d = ea_x - eb_x + BIAS_X;
          dvs_d = {1'b1, fb};
          rem_d = {2'b01, fa};
          quo_d = '0;
          cnt_d = CW'(M + 2);
        end
      end
      md_mul_iter: begin
        prod_d = {mul_sum, prod_q[M-1:1]};
        cnt_d  = cnt_q - CW'(1);
      end
      md_div_iter: begin
        rem_d = {div_diff[M-1:0], 1'b0};
        quo_d = {quo_q[M:0], div_ge};
        cnt_d = cnt_q - CW'(1);
      end
      md_norm: begin
        result_d          = rp_result;
        flags_d           = '0;
        flags_d[FLAG_OVF] = rp_ovf;
        flags_d[FLAG_UNF] = rp_unf;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= op_nop;
      opa_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      dvs_q    <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      dvs_q    <= dvs_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end
endmodule

// File: doc/fpu_seq_muldiv.md
Name: fpu_seq_muldiv

Overview:
Parametrised sequential floating-point multiply/divide unit for the Sol-1 FPU, the next generation of the fixed-width shift-add multiplier and restoring divider.
- Generalised to any exponent/mantissa split (IEEE-754-like, hidden bit, biased exponent).
- Adds special-value handling, exception flags and a held-result/ack handshake.
- Sits under the FPU main sequencer, which issues op_mul/op_div and waits for ack.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored mantissa width (hidden bit excluded)
BIAS, 2**(EXP_W-1)-1, exponent bias
W (local), 1+EXP_W+MAN_W, operand/result width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  accept operation when ready=1
op  in  4  e_fpu_operations code; only op_mul, op_div legal
opa  in  W  operand A (dividend)
opb  in  W  operand B (divisor)
ready  out  1  idle, can accept start
result  out  W  packed result, valid while out_valid=1
out_valid  out  1  result held until out_ack
out_ack  in  1  consumer acknowledge
flags  out  4  {invalid, div_by_zero, overflow, underflow}, valid with result

Behaviour:
- One clock domain, rising edge. Reset is synchronous and active-high; rst dominates every other input.
- Reset values: ready=1, out_valid=0, result=0, flags=0, state=md_idle.
- States:
  - md_idle: start&ready -> md_unpack, latch operands/op. ready=1 only here.
  - md_unpack: split fields; denormals flushed to zero. Special case -> md_result; else -> md_mul_iter or md_div_iter, counter loaded.
  - md_mul_iter: shift-add, one multiplier bit per cycle, MAN_W+1 cycles; product 2*(MAN_W+1) bits.
  - md_div_iter: restoring divide, one quotient bit per cycle, MAN_W+3 cycles (integer, MAN_W fraction, guard, round); sticky = remainder!=0.
  - md_norm: normalise, round, range-check, pack -> md_result.
  - md_result: out_valid=1, result/flags stable; out_ack -> md_idle, out_valid=0 next cycle.
- Latency, counted from the start-sample edge to out_valid high (MAN_W=23 values in brackets):
  - mul: MAN_W+4 (27)
  - div: MAN_W+6 (29)
  - special cases: 2
- Arithmetic:
  - mul: exp = ea+eb-BIAS, sign = sa^sb. If product MSB is set, shift right 1 and exp+1.
  - div: exp = ea-eb+BIAS. If quotient integer bit is 0, shift left 1 and exp-1.
  - Exponent is computed at EXP_W+2 bits signed.
- Range:
  - exp >= 2**EXP_W-1 -> signed infinity, overflow=1.
  - exp <= 0 -> signed zero, underflow=1.
- Special cases:
  - Any NaN input -> quiet NaN (exp all 1s, mantissa MSB 1, sign 0), invalid=0.
  - inf*0, 0/0, inf/inf -> quiet NaN, invalid=1.
  - x/0 with x finite nonzero -> signed inf, div_by_zero=1.
  - 0*x or 0/x -> signed zero.
  - inf*x or inf/x -> signed inf.
  - x/inf -> signed zero.
- op other than op_mul/op_div -> quiet NaN, invalid=1, 2-cycle path.
- Handshake edge cases:
  - start while ready=0 is ignored; no queueing.
  - out_ack while out_valid=0 is ignored.
  - out_ack coincident with out_valid rising is honoured on the next edge, so the result is visible for at least 1 cycle.
  - After ack, ready returns the next cycle; back-to-back throughput is latency+1.
- Reset mid-operation aborts immediately; no partial result and no out_valid.

Optional Feature:
- Macro: FPU_MULDIV_ROUND_NEAREST_EN.
- Defined: round-to-nearest-even in md_norm using guard, round and sticky bits. A mantissa carry-out renormalises (exp+1) and may raise overflow. Latency unchanged.
- Undefined: truncation (round toward zero); guard/sticky ignored.

Decomposition:
- Package pa_fpu:
  - add e_muldiv_states (md_idle, md_unpack, md_mul_iter, md_div_iter, md_norm, md_result);
  - flag index localparams FLAG_INVALID=3, FLAG_DZ=2, FLAG_OVF=1, FLAG_UNF=0;
  - reuse e_fpu_operations for op.
- One sub-module: fpu_round_pack. Combinational; takes sign, extended exponent, mantissa with guard/sticky; returns packed result plus overflow/underflow. It is shared with the future add/sub unit.

Test Plan:
- 0x3FC00000 * 0x40000000 (1.5*2.0) -> result 0x40400000, flags 0, out_valid exactly 27 cycles after start.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAA truncating, 0x3EAAAAAB with FPU_MULDIV_ROUND_NEAREST_EN, at 29 cycles.
- 0x3F800000 / 0x00000000 -> 0x7F800000, div_by_zero=1, latency 2.
- 0x00000000 * 0x7F800000 -> 0x7FC00000, invalid=1.
- 0x7F000000 * 0x40000000 -> 0x7F800000, overflow=1.
- 0x00800000 / 0x40000000 -> 0x00000000, underflow=1.
- Handshake and reset:
  - start pulsed mid-operation -> ignored, first result unchanged.
  - out_ack withheld 10 cycles -> result/flags stable throughout.
  - rst asserted at cycle 5 of a divide -> next cycle ready=1, out_valid=0, no result emitted.
